// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Sequencer for a multi-cycle, single-issue RV32I datapath. Each instruction
// is walked through FETCH -> DECODE -> EXECUTE -> (MEMORY) -> (WRITEBACK).
// The block drives the shared memory port handshake, the IR/PC/register-file
// write enables and the datapath mux selects. Illegal opcodes and memory
// requests that stall for MEM_TIMEOUT cycles park the sequencer in TRAP
// until reset.
//
// Optional feature (macro RETIRE_COUNTER_EN):
//   defined   : retired counts completed instructions (wraps modulo
//               2^COUNT_WIDTH)
//   undefined : no counter logic, retired is tied to 0
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   opcode[6:0]  in   instruction[6:0] from IR
//   funct3[2:0]  in   instruction[14:12] from IR
//   zero         in   ALU zero flag
//   mem_ready    in   memory completes the current request this cycle
//   mem_req      out  memory request, held until mem_ready
//   mem_we       out  store request (qualified by mem_req)
//   addr_sel     out  memory address: 0 = PC, 1 = ALU result
//   ir_write     out  load IR from memory read data
//   pc_write     out  update PC this cycle
//   pc_source    out  0 = PC+4, 1 = PC+imm, 2 = ALU result with bit0 cleared
//   alu_source   out  ALU operand B: 0 = immediate, 1 = rs2 data
//   should_write out  register-file write enable
//   wb_sel       out  0 = ALU result, 1 = memory data, 2 = PC+4
//   trap         out  sticky illegal-instruction / timeout flag
//   state[2:0]   out  current state encoding (debug)
//   retired      out  instructions completed
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int MEM_TIMEOUT = 255,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   addr_sel,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic [1:0]             pc_source,
  output logic                   alu_source,
  output logic                   should_write,
  output logic [1:0]             wb_sel,
  output logic                   trap,
  output logic [2:0]             state,
  output logic [COUNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_OP, C_OPIMM, C_LOAD, C_STORE,
    C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_t;

  function automatic cls_t classify(input logic [6:0] op);
    cls_t c;
    case (op)
      7'b0110011: c = C_OP;
      7'b0010011: c = C_OPIMM;
      7'b0000011: c = C_LOAD;
      7'b0100011: c = C_STORE;
      7'b1100011: c = C_BRANCH;
      7'b1101111: c = C_JAL;
      7'b1100111: c = C_JALR;
      7'b0110111: c = C_LUI;
      7'b0010111: c = C_AUIPC;
      default:    c = C_NONE;
    endcase
    return c;
  endfunction

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] to_q, to_d;
  logic        mem_wait;

  // Only funct3[0] (branch sense inversion) steers the sequencer; the other
  // bits are latched alongside it so the decoded instruction stays whole.
  logic unused_f3;
  assign unused_f3 = ^f3_q[2:1];

  assign state = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_NONE;
      f3_q    <= 3'd0;
      to_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      f3_q    <= f3_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    f3_d         = f3_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_source    = 2'd0;
    alu_source   = 1'b0;
    should_write = 1'b0;
    wb_sel       = 2'd0;
    trap         = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        // Class and funct3 are frozen here so the IR may change freely
        // until the next fetch.
        cls_d   = classify(opcode);
        f3_d    = funct3;
        state_d = (classify(opcode) == C_NONE) ? S_TRAP : S_EXECUTE;
      end

      S_EXECUTE: begin
        alu_source = (cls_q == C_OP) || (cls_q == C_BRANCH);
        case (cls_q)
          C_BRANCH: begin
            // ALU subtracts; zero means equal. funct3[0] flips BEQ into BNE.
            pc_write  = 1'b1;
            pc_source = {1'b0, zero ^ f3_q[0]};
            state_d   = S_FETCH;
          end
          C_LOAD, C_STORE: state_d = S_MEMORY;
          default:         state_d = S_WRITEBACK;
        endcase
      end

      S_MEMORY: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls_q == C_STORE);
        if (mem_ready) begin
          if (cls_q == C_STORE) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d  = S_WRITEBACK;
          end
        end
      end

      S_WRITEBACK: begin
        should_write = 1'b1;
        pc_write     = 1'b1;
        case (cls_q)
          C_LOAD:  wb_sel = 2'd1;
          C_JAL,
          C_JALR:  wb_sel = 2'd2;
          default: wb_sel = 2'd0;
        endcase
        case (cls_q)
          C_JAL:   pc_source = 2'd1;
          C_JALR:  pc_source = 2'd2;
          default: pc_source = 2'd0;
        endcase
        state_d = S_FETCH;
      end

      S_TRAP: begin
        trap = 1'b1;
      end

      default: state_d = S_TRAP;
    endcase

    // Stall watchdog: counts consecutive unanswered request cycles.
    mem_wait = mem_req && !mem_ready;
    to_d     = mem_wait ? (to_q + 32'd1) : 32'd0;
    if ((MEM_TIMEOUT != 0) && mem_wait && (to_q == 32'(MEM_TIMEOUT - 1)))
      state_d = S_TRAP;

    // Outputs must fall the instant reset asserts, even mid-request.
    if (reset) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      addr_sel     = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_source    = 2'd0;
      alu_source   = 1'b0;
      should_write = 1'b0;
      wb_sel       = 2'd0;
      trap         = 1'b0;
    end
  end

`ifdef RETIRE_COUNTER_EN
  // pc_write pulses exactly once per completed instruction, so it doubles
  // as the retire strobe.
  logic [COUNT_WIDTH-1:0] retired_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      retired_q <= '0;
    else if (pc_write)
      retired_q <= retired_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int CW = 32;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    opcode = 7'd0;
  logic [2:0]    funct3 = 3'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, addr_sel, ir_write, pc_write;
  logic [1:0]    pc_source, wb_sel;
  logic          alu_source, should_write, trap;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  multicycle_control #(.MEM_TIMEOUT(255), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write),
    .pc_source(pc_source), .alu_source(alu_source),
    .should_write(should_write), .wb_sel(wb_sel), .trap(trap),
    .state(state), .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_source;
    logic       should_write;
    logic [1:0] wb_sel;
    logic       trap;
  } obs_t;

  typedef struct {
    obs_t        v;
    obs_t        m;
    logic        chk_ret;
    logic [31:0] ret;
    string       tag;
  } exp_t;

  exp_t exq[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   ret_cnt = 0;

  obs_t act;
  assign act = '{st: state, mem_req: mem_req, mem_we: mem_we,
                 addr_sel: addr_sel, ir_write: ir_write, pc_write: pc_write,
                 pc_source: pc_source, alu_source: alu_source,
                 should_write: should_write, wb_sel: wb_sel, trap: trap};

  // Monitor: one expected observation per scheduled cycle, sampled mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    if (exq.size() > 0) begin
      e = exq.pop_front();
      n_cmp++;
      if (((act ^ e.v) & e.m) !== '0) begin
        n_fail++;
        $display("FAIL cycle %s: got %h required %h (care %h) at %0t",
                 e.tag, act, e.v, e.m, $time);
      end
      if (e.chk_ret) begin
        n_cmp++;
        if (retired !== e.ret) begin
          n_fail++;
          $display("FAIL retired %s: got %0d required %0d", e.tag, retired, e.ret);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] x);
    n_cmp++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, a, x);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [2:0] st);
    exp_t e;
    e.v            = '0;
    e.v.st         = st;
    e.m            = '1;
    e.m.pc_source  = 2'b00;
    e.m.alu_source = 1'b0;
    e.m.wb_sel     = 2'b00;
    e.chk_ret      = 1'b0;
    e.ret          = 32'd0;
    e.tag          = tag;
    return e;
  endfunction

  function automatic logic [31:0] exp_ret();
`ifdef RETIRE_COUNTER_EN
    return 32'(ret_cnt);
`else
    return 32'd0;
`endif
  endfunction

  // Called at posedge+1: apply this cycle's input, queue its expectation.
  task automatic step(input logic mr, input exp_t e);
    mem_ready = mr;
    exq.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_state"},   32'(state),   32'd0);
    chk({tag, "_trap"},    32'(trap),    32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_retired"}, retired,      32'd0);
    @(posedge clock);
    #1;
    reset   = 1'b0;
    ret_cnt = 0;
  endtask

  task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic z, input int fw, input int mw, input bit abort_mem);
    exp_t e;
    bit ld, st, br, jl, jr, legal;
    ld = (op == OP_LOAD);
    st = (op == OP_STORE);
    br = (op == OP_BRANCH);
    jl = (op == OP_JAL);
    jr = (op == OP_JALR);
    legal = ld || st || br || jl || jr || (op == OP_OP) || (op == OP_OPIMM) ||
            (op == OP_LUI) || (op == OP_AUIPC);
    zero   = z;
    opcode = 7'd0;
    funct3 = f3;
    for (int i = 0; i <= fw; i++) begin
      e = mk(tag, 3'd0);
      e.v.mem_req  = 1'b1;
      e.v.ir_write = (i == fw);
      step(i == fw, e);
    end
    opcode = op;
    e = mk(tag, 3'd1);
    step(1'b0, e);
    // IR contents after decode must not matter any more.
    opcode = 7'h7f;
    funct3 = ~f3;
    if (!legal) begin
      for (int i = 0; i < 4; i++) begin
        e = mk(tag, 3'd7);
        e.v.trap = 1'b1;
        step(1'b1, e);
      end
      return;
    end
    e = mk(tag, 3'd2);
    e.m.alu_source = 1'b1;
    e.v.alu_source = (op == OP_OP) || br;
    if (br) begin
      e.v.pc_write  = 1'b1;
      e.m.pc_source = 2'b11;
      e.v.pc_source = {1'b0, z ^ f3[0]};
      e.chk_ret = 1'b1; e.ret = exp_ret(); ret_cnt++;
      step(1'b0, e);
      return;
    end
    step(1'b0, e);
    if (ld || st) begin
      for (int i = 0; i <= mw; i++) begin
        if (abort_mem && i == mw) return;
        e = mk(tag, 3'd3);
        e.v.mem_req  = 1'b1;
        e.v.addr_sel = 1'b1;
        e.v.mem_we   = st;
        if (st && i == mw) begin
          e.v.pc_write  = 1'b1;
          e.m.pc_source = 2'b11;
          e.v.pc_source = 2'd0;
          e.chk_ret = 1'b1; e.ret = exp_ret(); ret_cnt++;
        end
        step(i == mw, e);
      end
      if (st) return;
    end
    e = mk(tag, 3'd4);
    e.v.should_write = 1'b1;
    e.v.pc_write     = 1'b1;
    e.m.wb_sel       = 2'b11;
    e.m.pc_source    = 2'b11;
    e.v.wb_sel       = ld ? 2'd1 : ((jl || jr) ? 2'd2 : 2'd0);
    e.v.pc_source    = jl ? 2'd1 : (jr ? 2'd2 : 2'd0);
    e.chk_ret = 1'b1; e.ret = exp_ret(); ret_cnt++;
    step(1'b0, e);
  endtask

  initial begin
    exp_t e;
    @(posedge clock);
    #1;
    do_reset("rst0");

    run("op",       OP_OP,     3'b000, 1'b0, 0, 0, 1'b0);
    run("load_w",   OP_LOAD,   3'b010, 1'b0, 2, 1, 1'b0);
    run("beq_t",    OP_BRANCH, 3'b000, 1'b1, 0, 0, 1'b0);
    run("beq_nt",   OP_BRANCH, 3'b000, 1'b0, 0, 0, 1'b0);
    run("bne_t",    OP_BRANCH, 3'b001, 1'b0, 0, 0, 1'b0);
    run("bne_nt",   OP_BRANCH, 3'b001, 1'b1, 1, 0, 1'b0);
    run("store",    OP_STORE,  3'b010, 1'b0, 0, 0, 1'b0);
    run("store_w",  OP_STORE,  3'b000, 1'b1, 1, 2, 1'b0);
    run("opimm",    OP_OPIMM,  3'b000, 1'b0, 0, 0, 1'b0);
    run("lui",      OP_LUI,    3'b000, 1'b0, 0, 0, 1'b0);
    run("auipc",    OP_AUIPC,  3'b000, 1'b0, 0, 0, 1'b0);
    run("jal",      OP_JAL,    3'b000, 1'b0, 0, 0, 1'b0);
    run("jalr",     OP_JALR,   3'b000, 1'b0, 0, 0, 1'b0);
    run("load",     OP_LOAD,   3'b000, 1'b0, 0, 0, 1'b0);

    run("illegal",  7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0);
    do_reset("rst_trap");

    // Fetch that is never answered: 255 waiting cycles, then TRAP.
    for (int i = 0; i < 255; i++) begin
      e = mk("timeout", 3'd0);
      e.v.mem_req = 1'b1;
      step(1'b0, e);
    end
    for (int i = 0; i < 2; i++) begin
      e = mk("timeout_trap", 3'd7);
      e.v.trap = 1'b1;
      step(1'b0, e);
    end
    do_reset("rst_to");

    // Reset in the middle of a stalled load access.
    run("ld_abort", OP_LOAD, 3'b000, 1'b0, 0, 2, 1'b1);
    mem_ready = 1'b0;
    chk("abort_pre_state",   32'(state),   32'd3);
    chk("abort_pre_mem_req", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_state",   32'(state),   32'd0);
    @(posedge clock);
    #1;
    reset   = 1'b0;
    ret_cnt = 0;
    chk("abort_retired", retired, 32'd0);
    run("op_after", OP_OP, 3'b000, 1'b0, 0, 0, 1'b0);

    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    chk("queue_drained", 32'(exq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
